// File: rtl/and_gate_unit.sv
// Bitwise AND of two operand buses with a zero-latency combinational result
// and a one-cycle registered result carrying a valid flag and summary flags.
module and_gate_unit #(
  parameter int WIDTH = 1,
  localparam int CNTW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one,
  output logic [CNTW-1:0]  ones_cnt
);

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] r_y_q;
  logic             r_out_valid;
  logic [CNTW-1:0]  w_ones_cnt;

  // Kept outside the reset domain so y tracks a & b even while rst_n is low.
  assign w_and = a & b;
  assign y     = w_and;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        r_y_q <= w_and;
      end
      r_out_valid <= in_valid;
    end
  end

  // Flags are decoded from the register itself, so they can never disagree with y_q.
  always_comb begin
    w_ones_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones_cnt = w_ones_cnt + CNTW'(r_y_q[i]);
    end
  end

  assign y_q       = r_y_q;
  assign out_valid = r_out_valid;
  assign all_ones  = &r_y_q;
  assign any_one   = |r_y_q;
  assign ones_cnt  = w_ones_cnt;

endmodule

// File: tb/tb_and_gate_unit.sv
// Directed and random checks of and_gate_unit at WIDTH 1, 8 and 16 against
// hand-computed values and a one-cycle-delayed reference model.
module tb_and_gate_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // WIDTH=1 instance
  logic       a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0;
  logic       y1, yq1, ov1, all1, any1;
  logic [0:0] cnt1;
  and_gate_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .y(y1), .y_q(yq1), .out_valid(ov1), .all_ones(all1), .any_one(any1), .ones_cnt(cnt1)
  );

  // WIDTH=8 instance
  logic [7:0] a8 = '0, b8 = '0;
  logic       iv8 = 1'b0;
  logic [7:0] y8, yq8;
  logic       ov8, all8, any8;
  logic [3:0] cnt8;
  and_gate_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
    .y(y8), .y_q(yq8), .out_valid(ov8), .all_ones(all8), .any_one(any8), .ones_cnt(cnt8)
  );

  // WIDTH=16 instance
  logic [15:0] a16 = '0, b16 = '0;
  logic        iv16 = 1'b0;
  logic [15:0] y16, yq16;
  logic        ov16, all16, any16;
  logic [4:0]  cnt16;
  and_gate_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(iv16),
    .y(y16), .y_q(yq16), .out_valid(ov16), .all_ones(all16), .any_one(any16), .ones_cnt(cnt16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] m_q;
  logic        m_v;

  initial begin
    // Test 1: WIDTH=1 truth table with reset held, no clock dependence for y.
    a1 = 0; b1 = 0; #1 chk("t1_y_00", 32'(y1), 32'd0); #9;
    a1 = 0; b1 = 1; #1 chk("t1_y_01", 32'(y1), 32'd0); #9;
    a1 = 1; b1 = 0; #1 chk("t1_y_10", 32'(y1), 32'd0); #9;
    a1 = 1; b1 = 1; #1 chk("t1_y_11", 32'(y1), 32'd1); #9;

    // Reset state of every instance.
    chk("rst_yq1", 32'(yq1), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_yq8", 32'(yq8), 32'd0);
    chk("rst_cnt8", 32'(cnt8), 32'd0);
    chk("rst_any8", 32'(any8), 32'd0);
    chk("rst_yq16", 32'(yq16), 32'd0);
    chk("rst_ov16", 32'(ov16), 32'd0);

    @(negedge clk) rst_n = 1'b1;

    // Test 2: capture 1 at WIDTH=1, then asynchronous reset mid-cycle.
    a1 = 1; b1 = 1; iv1 = 1;
    @(negedge clk);
    chk("t2_yq1_cap", 32'(yq1), 32'd1);
    chk("t2_ov1_cap", 32'(ov1), 32'd1);
    chk("t2_all1_cap", 32'(all1), 32'd1);
    chk("t2_any1_cap", 32'(any1), 32'd1);
    chk("t2_cnt1_cap", 32'(cnt1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t2_yq1_rst", 32'(yq1), 32'd0);
    chk("t2_ov1_rst", 32'(ov1), 32'd0);
    chk("t2_all1_rst", 32'(all1), 32'd0);
    chk("t2_any1_rst", 32'(any1), 32'd0);
    chk("t2_cnt1_rst", 32'(cnt1), 32'd0);
    chk("t2_y1_in_rst", 32'(y1), 32'd1);
    a1 = 0;
    #1 chk("t2_y1_track", 32'(y1), 32'd0);
    @(negedge clk);
    chk("t2_yq1_held_rst", 32'(yq1), 32'd0);
    iv1 = 0;
    rst_n = 1'b1;

    // Test 3: F0 & 3C.
    a8 = 8'hF0; b8 = 8'h3C; iv8 = 1;
    #1 chk("t3_y8", 32'(y8), 32'h30);
    @(negedge clk);
    chk("t3_yq8", 32'(yq8), 32'h30);
    chk("t3_ov8", 32'(ov8), 32'd1);
    chk("t3_any8", 32'(any8), 32'd1);
    chk("t3_all8", 32'(all8), 32'd0);
    chk("t3_cnt8", 32'(cnt8), 32'd2);

    // Test 4: all ones, then stale hold.
    a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    chk("t4_yq8", 32'(yq8), 32'hFF);
    chk("t4_all8", 32'(all8), 32'd1);
    chk("t4_cnt8", 32'(cnt8), 32'd8);
    iv8 = 0; a8 = 8'h00;
    #1 chk("t4_y8_zero", 32'(y8), 32'd0);
    @(negedge clk);
    chk("t4_yq8_hold", 32'(yq8), 32'hFF);
    chk("t4_ov8_stale", 32'(ov8), 32'd0);
    chk("t4_all8_hold", 32'(all8), 32'd1);
    chk("t4_cnt8_hold", 32'(cnt8), 32'd8);

    // Test 5: back-to-back 01, 00, AA.
    iv8 = 1; a8 = 8'h01; b8 = 8'hFF;
    @(negedge clk);
    chk("t5_yq8_a", 32'(yq8), 32'h01);
    chk("t5_cnt8_a", 32'(cnt8), 32'd1);
    chk("t5_ov8_a", 32'(ov8), 32'd1);
    a8 = 8'h00;
    @(negedge clk);
    chk("t5_yq8_b", 32'(yq8), 32'h00);
    chk("t5_cnt8_b", 32'(cnt8), 32'd0);
    chk("t5_any8_b", 32'(any8), 32'd0);
    chk("t5_ov8_b", 32'(ov8), 32'd1);
    a8 = 8'hAA;
    @(negedge clk);
    chk("t5_yq8_c", 32'(yq8), 32'hAA);
    chk("t5_cnt8_c", 32'(cnt8), 32'd4);
    chk("t5_ov8_c", 32'(ov8), 32'd1);
    iv8 = 0;

    // Test 6: random WIDTH=16 against a delayed model.
    m_q = '0;
    m_v = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("t6_yq16", 32'(yq16), 32'(m_q));
      chk("t6_ov16", 32'(ov16), 32'(m_v));
      chk("t6_all16", 32'(all16), 32'(m_q == 16'hFFFF));
      chk("t6_any16", 32'(any16), 32'(m_q != 16'h0000));
      chk("t6_cnt16", 32'(cnt16), 32'($countones(m_q)));
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      iv16 = 1'($urandom_range(0, 1));
      if (i % 97 == 0) a16 = 16'hFFFF;
      if (i % 97 == 0) b16 = 16'hFFFF;
      #1 chk("t6_y16", 32'(y16), 32'(a16 & b16));
      if (iv16) m_q = a16 & b16;
      m_v = iv16;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
